// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the processor core's load/store
// path and a host port used to preload operands and read back results.
//
// Policy
//   SHARE : the core wins a conflict, but once the host has waited MAX_WAIT
//           consecutive cycles it is granted and the core stalls for that one
//           cycle.
//   OWN   : entered when a host grant carries host_lock. The host is granted
//           on every request and the core stalls whenever it requests. Left on
//           the first edge where host_lock is low.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   core_req/we/addr/wdata  core access request (held while core_stall = 1)
//   core_rdata              load data, combinational copy of mem_rdata
//   core_stall              core must hold PC and request this cycle
//   host_req/we/lock/addr/wdata  host request, held until host_gnt
//   host_gnt                host request accepted this cycle
//   host_rvalid/host_rdata  registered host read data, rvalid is a 1-cycle pulse
//   mem_wr_en/rd_en/addr/wdata, mem_rdata   to/from dat_mem (combinational read)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // core load/store path
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  // host port
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  // data memory
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {
    ST_SHARE = 1'b0,
    ST_OWN   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wcnt;
  logic          core_served;

  // Load data is never registered here: the core sees the memory's
  // combinational read in the same cycle it is served.
  assign core_rdata = mem_rdata;

  // ---------------------------------------------------------------------------
  // Grant, stall, memory mux and next state.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    host_gnt    = 1'b0;
    core_stall  = 1'b0;
    core_served = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    state_nxt   = state;

    // While reset is low everything stays at its default, so grants, stalls
    // and memory strobes drop immediately, even in the middle of a cycle.
    if (reset) begin
      case (state)
        ST_SHARE: begin
          // Core has priority until the host has waited MAX_WAIT cycles.
          host_gnt    = host_req & (~core_req | (wcnt == WAIT_MAX));
          core_stall  = core_req & host_gnt;
          core_served = core_req & ~host_gnt;
          if (host_gnt && host_lock) state_nxt = ST_OWN;
        end
        ST_OWN: begin
          host_gnt    = host_req;
          core_stall  = core_req;
          if (!host_lock) state_nxt = ST_SHARE;
        end
      endcase

      if (host_gnt) begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_wr_en = host_we;
        mem_rd_en = ~host_we;
      end else if (core_served) begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_wr_en = core_we;
        mem_rd_en = ~core_we;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, wait counter and host read-data register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SHARE;
      wcnt        <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state <= state_nxt;

      // Counts consecutive cycles the host has been refused; any grant or a
      // dropped request starts the count over.
      if (host_req && !host_gnt) begin
        if (wcnt != WAIT_MAX) wcnt <= wcnt + WW'(1);
      end else begin
        wcnt <= '0;
      end

      // rvalid pulses for exactly the cycle after a host read grant; the data
      // itself is held until the next host read.
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives directed scenarios and a randomized phase into dmem_arbiter. A
// reference model (ownership flag, host wait count, memory image) predicts
// grant/stall/memory strobes every cycle; host read results are pushed into a
// scoreboard queue and popped by an independent monitor whenever host_rvalid
// is seen. A behavioural dat_mem sits on the memory port.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_lock  (host_lock),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural dat_mem: combinational read, write on the rising edge.
  logic [DW-1:0] env_mem [256];
  logic          env_clear;
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
    end else if (mem_wr_en) begin
      env_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = env_mem[mem_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int rv_count = 0;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  logic [DW-1:0] ref_mem [256];
  logic          m_owned;
  int            m_wait;
  logic [DW-1:0] m_last_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owned      = 1'b0;
    m_wait       = 0;
    m_last_rdata = '0;
    sb.delete();
  endtask

  // Monitor: every host_rvalid must match the oldest outstanding read, and
  // every outstanding read must be answered in the cycle it is due.
  always @(negedge clk) begin
    rd_exp_t e;
    if (host_rvalid) begin
      rv_count++;
      if (sb.size() == 0) begin
        check("host_rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("host_rvalid_due", cyc, e.due);
        check("host_rdata", {24'd0, host_rdata}, {24'd0, e.data});
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("host_rvalid_missing", {31'd0, host_rvalid}, 32'd1);
    end
  end

  // One clock cycle: apply inputs (entered just after a rising edge), compare
  // against the model at the falling edge, then advance the model at the edge.
  task automatic step(input logic c_req, input logic c_we,
                      input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                      input logic h_req, input logic h_we, input logic h_lock,
                      input logic [AW-1:0] h_addr, input logic [DW-1:0] h_wd,
                      output logic o_gnt, output logic o_stall,
                      output logic [DW-1:0] o_crd);
    logic          e_gnt, e_stall, e_served, e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    rd_exp_t       e;
    core_req   = c_req;
    core_we    = c_we;
    core_addr  = c_addr;
    core_wdata = c_wd;
    host_req   = h_req;
    host_we    = h_we;
    host_lock  = h_lock;
    host_addr  = h_addr;
    host_wdata = h_wd;
    @(negedge clk);
    // Host wins if it owns memory, the core is idle, or it has waited long enough.
    e_gnt    = h_req && (m_owned || !c_req || m_wait >= MAX_WAIT);
    e_stall  = c_req && (m_owned || e_gnt);
    e_served = c_req && !e_stall;
    e_wr     = (e_gnt && h_we)  || (e_served && c_we);
    e_rd     = (e_gnt && !h_we) || (e_served && !c_we);
    e_addr   = e_gnt ? h_addr : (e_served ? c_addr : '0);
    e_wd     = e_gnt ? h_wd   : (e_served ? c_wd   : '0);
    check("host_gnt",   {31'd0, host_gnt},   {31'd0, e_gnt});
    check("core_stall", {31'd0, core_stall}, {31'd0, e_stall});
    check("mem_wr_en",  {31'd0, mem_wr_en},  {31'd0, e_wr});
    check("mem_rd_en",  {31'd0, mem_rd_en},  {31'd0, e_rd});
    check("mem_addr",   {24'd0, mem_addr},   {24'd0, e_addr});
    check("mem_wdata",  {24'd0, mem_wdata},  {24'd0, e_wd});
    check("host_rdata_hold", {24'd0, host_rdata}, {24'd0, m_last_rdata});
    if (e_served && !c_we)
      check("core_rdata", {24'd0, core_rdata}, {24'd0, ref_mem[c_addr]});
    if (e_gnt && !h_we) begin
      e.due  = cyc + 1;
      e.data = ref_mem[h_addr];
      sb.push_back(e);
    end
    o_gnt   = host_gnt;
    o_stall = core_stall;
    o_crd   = core_rdata;
    @(posedge clk);
    if (e_gnt && h_we)    ref_mem[h_addr] = h_wd;
    if (e_served && c_we) ref_mem[c_addr] = c_wd;
    if (e_gnt && !h_we)   m_last_rdata = e.data;
    if (h_req && !e_gnt) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else                 m_wait = 0;
    if (!m_owned && e_gnt && h_lock) m_owned = 1'b1;
    else if (m_owned && !h_lock)     m_owned = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic          g, s;
    logic [DW-1:0] d;
    int            ngnt, nstall, first_gnt, rv0, nbad;
    logic          r_creq, r_cwe, r_hreq, r_hwe, r_hlock;
    logic [AW-1:0] r_caddr, r_haddr;
    logic [DW-1:0] r_cwd, r_hwd;
    logic          h_pending, c_stalled;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();

    // Reset with requests active: strobes, grant and stall must stay low.
    reset      = 1'b0;
    env_clear  = 1'b1;
    core_req   = 1'b1;  core_we = 1'b1;  core_addr = 8'h11;  core_wdata = 8'h22;
    host_req   = 1'b1;  host_we = 1'b1;  host_lock = 1'b1;
    host_addr  = 8'h12; host_wdata = 8'h34;
    @(posedge clk); #1;
    env_clear  = 1'b0;
    @(negedge clk);
    check("rst_host_gnt",    {31'd0, host_gnt},    32'd0);
    check("rst_core_stall",  {31'd0, core_stall},  32'd0);
    check("rst_mem_wr_en",   {31'd0, mem_wr_en},   32'd0);
    check("rst_mem_rd_en",   {31'd0, mem_rd_en},   32'd0);
    check("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_host_rdata",  {24'd0, host_rdata},  32'd0);
    check("rst_mem_addr",    {24'd0, mem_addr},    32'd0);
    @(posedge clk); #1;
    check("rst_no_write", {24'd0, env_mem[8'h11]}, 32'd0);
    reset = 1'b1;

    // Core only: write then read back with no stall.
    step(1, 1, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("core_only_wr_stall", {31'd0, s}, 32'd0);
    step(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("core_only_rdata", {24'd0, d}, 32'h5A);

    // Host in an idle slot: preload 0x20, then read it.
    step(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'h33, g, s, d);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, g, s, d);
    check("idle_host_gnt", {31'd0, g}, 32'd1);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("idle_host_rdata", {24'd0, host_rdata}, 32'h33);

    // Starvation bound: core requests every cycle, host waits MAX_WAIT cycles.
    r_hreq = 1'b1;
    for (int k = 0; k <= MAX_WAIT + 1; k++) begin
      step(1, 0, 8'h10, 8'h00, r_hreq, 1, 0, 8'h30, 8'h77, g, s, d);
      check($sformatf("starve_gnt_c%0d", k), {31'd0, g}, (k == MAX_WAIT) ? 32'd1 : 32'd0);
      check($sformatf("starve_stall_c%0d", k), {31'd0, s}, (k == MAX_WAIT) ? 32'd1 : 32'd0);
      if (g) r_hreq = 1'b0;
    end

    // Lock mode: 8 locked host writes against a continuously requesting core.
    ngnt = 0; nstall = 0; first_gnt = -1;
    for (int k = 0; k <= MAX_WAIT + 1 && first_gnt < 0; k++) begin
      step(1, 0, 8'h10, 8'h00, 1, 1, 1, 8'h80, 8'h01, g, s, d);
      if (g) begin first_gnt = k; ngnt++; nstall += s; end
    end
    check("lock_first_gnt_cycle", first_gnt, MAX_WAIT);
    for (int k = 1; k < 8; k++) begin
      step(1, 0, 8'h10, 8'h00, 1, 1, 1, 8'h80 + 8'(k), 8'(k + 1), g, s, d);
      ngnt += g;
      nstall += s;
    end
    check("lock_grants", ngnt, 8);
    check("lock_stalls", nstall, 8);
    step(1, 0, 8'h83, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    step(1, 0, 8'h83, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("unlock_core_served", {31'd0, s}, 32'd0);
    check("unlock_core_rdata", {24'd0, d}, 32'h04);

    // Read data hold: one read, then a write; rdata must keep the read value.
    rv0 = rv_count;
    step(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h40, 8'h99, g, s, d);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, g, s, d);
    step(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h41, 8'h12, g, s, d);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("hold_rdata", {24'd0, host_rdata}, 32'h99);
    check("hold_rvalid_pulses", rv_count - rv0, 1);

    // Reset in the middle of a locked host write.
    step(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h50, 8'hA1, g, s, d);
    core_req  = 1'b1;  core_we    = 1'b0;  core_addr = 8'h10;  core_wdata = 8'h00;
    host_req  = 1'b1;  host_we    = 1'b1;  host_lock = 1'b1;
    host_addr = 8'h90; host_wdata = 8'hEE;
    #2;
    check("own_pre_rst_wr_en", {31'd0, mem_wr_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en",  {31'd0, mem_wr_en},  32'd0);
    check("mid_rst_gnt",    {31'd0, host_gnt},   32'd0);
    check("mid_rst_stall",  {31'd0, core_stall}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("mid_rst_no_commit", {24'd0, env_mem[8'h90]}, {24'd0, ref_mem[8'h90]});
    check("mid_rst_rvalid",    {31'd0, host_rvalid},    32'd0);
    check("mid_rst_rdata",     {24'd0, host_rdata},     32'd0);
    host_req = 1'b0;
    core_req = 1'b0;
    reset    = 1'b1;
    // Back in SHARE with a cleared wait count: grant arrives after MAX_WAIT.
    first_gnt = -1;
    r_hreq    = 1'b1;
    for (int k = 0; k <= MAX_WAIT + 1; k++) begin
      step(1, 0, 8'h10, 8'h00, r_hreq, 0, 0, 8'h50, 8'h00, g, s, d);
      if (g && first_gnt < 0) begin first_gnt = k; r_hreq = 1'b0; end
    end
    check("post_rst_gnt_cycle", first_gnt, MAX_WAIT);

    // Randomized traffic obeying the hold rules of both requesters.
    h_pending = 1'b0;
    c_stalled = 1'b0;
    r_creq = 0; r_cwe = 0; r_caddr = '0; r_cwd = '0;
    r_hreq = 0; r_hwe = 0; r_hlock = 0; r_haddr = '0; r_hwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!c_stalled) begin
        r_creq  = ($urandom_range(0, 3) != 0);
        r_cwe   = $urandom_range(0, 1) != 0;
        r_caddr = 8'hC0 + 8'($urandom_range(0, 15));
        r_cwd   = 8'($urandom);
      end
      if (!h_pending) begin
        r_hreq  = ($urandom_range(0, 2) == 0);
        r_hwe   = $urandom_range(0, 1) != 0;
        r_hlock = m_owned ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
        r_haddr = 8'hC0 + 8'($urandom_range(0, 15));
        r_hwd   = 8'($urandom);
      end
      step(r_creq, r_cwe, r_caddr, r_cwd, r_hreq, r_hwe, r_hlock, r_haddr, r_hwd, g, s, d);
      h_pending = r_hreq && !g;
      c_stalled = s;
    end

    // Drain: release ownership and let the last read answer.
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, g, s, d);
    check("scoreboard_empty", sb.size(), 0);

    nbad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) nbad++;
    check("mem_image_mismatches", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the processor core and a host port used for preloading operands and reading back results. It sits between the core's load/store path (ALU result as address, register B as write data, MemWrite/MemtoReg as request) and `dat_mem`. The core has priority, but a bounded-wait counter guarantees host progress. A lock mode lets the host own memory for bulk transfers while the core stalls.

## Interface
- `AW`, 8, memory address width (matches the 8-bit ALU result)
- `DW`, 8, data width
- `MAX_WAIT`, 4, consecutive host-waiting cycles before the core is forced to stall; must be ≥1

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core memory access this cycle (MemWrite | MemtoReg)
- `core_we`  in  1  core write (1) / read (0)
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core store data
- `core_rdata`  out  DW  core load data, combinational from `mem_rdata`
- `core_stall`  out  1  core must hold PC and all request inputs this cycle
- `host_req`  in  1  host request, held until granted
- `host_we`  in  1  host write / read
- `host_lock`  in  1  on grant, take exclusive ownership
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_gnt`  out  1  host request accepted this cycle
- `host_rvalid`  out  1  `host_rdata` valid (one-cycle pulse)
- `host_rdata`  out  DW  registered host read data
- `mem_wr_en`, `mem_rd_en`  out  1  to `dat_mem`
- `mem_addr`  out  AW  to `dat_mem`
- `mem_wdata`  out  DW  to `dat_mem`
- `mem_rdata`  in  DW  from `dat_mem` (combinational read)

## Operation
- States: SHARE (reset) and OWN. Wait counter `wcnt`, width clog2(MAX_WAIT+1), resets to 0.
- SHARE grant:
  - `host_gnt = host_req & (!core_req | wcnt==MAX_WAIT)`.
  - Core is served iff `core_req & !host_gnt`.
  - `core_stall = core_req & host_gnt`.
- OWN grant:
  - `host_gnt = host_req`.
  - `core_stall = core_req`.
  - The core is never served.
- Memory mux:
  - The granted side drives `mem_addr` and `mem_wdata`.
  - `mem_wr_en = granted & we`; `mem_rd_en = granted & !we`.
  - With no grant, all memory outputs are 0.
  - `core_rdata = mem_rdata` always. It is meaningful only when the core is served.
- `wcnt`:
  - Increments (saturating at MAX_WAIT) each edge where `host_req & !host_gnt`.
  - Clears to 0 on any edge with `host_gnt` or with `!host_req`.
- Transitions:
  - SHARE→OWN on an edge where `host_gnt & host_lock`.
  - OWN→SHARE on an edge where `!host_lock`.
  - Otherwise hold.
- Host read: on an edge with `host_gnt & !host_we`, capture `mem_rdata` into `host_rdata` and set `host_rvalid` for exactly the next cycle. `host_rdata` holds its value until the next host read.
- Reset (`reset`=0, asynchronous, any time including mid-access):
  - State→SHARE, `wcnt`=0, `host_rvalid`=0, `host_rdata`=0.
  - `mem_wr_en`, `mem_rd_en`, `host_gnt` and `core_stall` are forced to 0 combinationally while `reset` is low.
  - No write is committed at an edge during reset.

## Timing
- Core access: zero added latency when served. Write commits at the edge ending the served cycle. Read data arrives the same cycle.
- Host grant: combinational in the request cycle. A write commits at that cycle's closing edge. A read produces `host_rvalid`=1 one cycle after the grant.
- Worst-case host latency in SHARE with the core continuously requesting: grant in cycle MAX_WAIT after `host_req` rises (cycle 0 = first request cycle).
- The core stall caused by a forced grant lasts exactly one cycle per forced access.
- `host_lock` is sampled only at grant (entry) and each OWN cycle (exit). A lock released mid-OWN returns to SHARE at the next edge. Core service resumes in the cycle after that edge.
- Back-to-back host requests in OWN: one grant per cycle, with no bubbles.
- Reset values: all outputs 0 except `core_rdata`, which follows `mem_rdata`.

## Test plan
- **Core only:** core writes 0x5A to 0x10, then reads 0x10 → served with no stall. `mem_wr_en`=1 in cycle 0; `core_rdata`=0x5A in cycle 1.
- **Host idle-slot:** host reads 0x20 (preloaded 0x33) with `core_req`=0 → `host_gnt` in cycle 0; `host_rvalid`=1 and `host_rdata`=0x33 in cycle 1; `core_stall` never asserted.
- **Starvation bound:** `core_req` held high, `host_req` from cycle 0, MAX_WAIT=4 → `host_gnt`=0 in cycles 0–3, `host_gnt`=`core_stall`=1 in cycle 4, core served again in cycle 5 and `wcnt`=0.
- **Lock mode:** host writes 0x01..0x08 to 0x80..0x87 with `host_lock`=1 while the core requests continuously → 8 consecutive grants, `core_stall`=1 throughout. Lock drops after the last grant → core served the next cycle.
- **Reset mid-access:** assert `reset`=0 during a host write grant in OWN → `mem_wr_en` drops immediately, memory is unchanged. After release: SHARE, `host_rvalid`=0, `wcnt`=0.
- **Read data hold:** host read 0x40=0x99, then a host write → `host_rdata` stays 0x99 and `host_rvalid` pulses only once.
